// File: rtl/pipe_stage_fifo_pkg.sv
// Shared types and helpers for the pipe_stage_fifo inter-stage buffer.
// Stage payload typedefs live in liang_pkg. This package holds only FIFO-generic items.
package pipe_stage_fifo_pkg;

   // Per-cycle storage operation, encoded as {pop, push}
   typedef enum logic [1:0] {
      OP_IDLE = 2'b00,
      OP_PUSH = 2'b01,
      OP_POP  = 2'b10,
      OP_BOTH = 2'b11
   } fifo_op_e;

   // Pointer width is at least one bit, so DEPTH=1 still has a legal vector
   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/pipe_fifo_ptr.sv
// Wrapping index into DEPTH-entry circular storage. It advances on inc and clears to 0.
// It wraps to 0 after DEPTH-1. With DEPTH=1 it stays at 0.
module pipe_fifo_ptr
   import pipe_stage_fifo_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int PTR_W = ptr_width(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             inc,
   output logic [PTR_W-1:0] ptr
);

   // NOTE: non-blocking assignments keep every register sampling pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (clear) begin
         ptr <= '0;
      end else if (inc) begin
         ptr <= (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
      end
   end

endmodule

// File: rtl/pipe_stage_fifo.sv
// DEPTH-entry inter-stage FIFO with flush. It replaces the single valid/ready hand-off.
// Optional fall-through when empty is enabled by the PIPE_FIFO_BYPASS_EN macro.
module pipe_stage_fifo
   import pipe_stage_fifo_pkg::*;
#(
   parameter  int WIDTH = 64,
   parameter  int DEPTH = 2,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] in_data_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] out_data_o,
   output logic [CNT_W-1:0] count_o
);

   localparam int PTR_W = ptr_width(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [CNT_W-1:0] cnt;
   logic [PTR_W-1:0] wp;
   logic [PTR_W-1:0] rp;
   logic             push;
   logic             pop;
   logic             thru;
   logic             wr;
   logic             rd;
   fifo_op_e         op;

   assign in_ready_o = (cnt != CNT_W'(DEPTH));
   assign count_o    = cnt;

`ifdef PIPE_FIFO_BYPASS_EN
   assign out_valid_o = (cnt != '0) | in_valid_i;
   assign out_data_o  = (cnt == '0) ? in_data_i : mem[rp];
   // Beat presented and taken while empty: it never touches storage
   assign thru        = (cnt == '0) & in_valid_i & out_ready_i;
`else
   assign out_valid_o = (cnt != '0);
   assign out_data_o  = mem[rp];
   assign thru        = 1'b0;
`endif

   assign push = in_valid_i & in_ready_o;
   assign pop  = out_valid_o & out_ready_i;
   assign wr   = push & ~thru;
   assign rd   = pop & ~thru;
   assign op   = fifo_op_e'({rd, wr});

   pipe_fifo_ptr #(.DEPTH(DEPTH)) u_wp (
      .clk   (clk_i),
      .rst_n (rst_i),
      .clear (flush_i),
      .inc   (wr),
      .ptr   (wp)
   );

   pipe_fifo_ptr #(.DEPTH(DEPTH)) u_rp (
      .clk   (clk_i),
      .rst_n (rst_i),
      .clear (flush_i),
      .inc   (rd),
      .ptr   (rp)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt <= '0;
      end else if (flush_i) begin
         cnt <= '0;
      end else begin
         case (op)
            OP_PUSH: cnt <= cnt + CNT_W'(1);
            OP_POP:  cnt <= cnt - CNT_W'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // NOTE: storage has no reset. Validity is carried entirely by cnt, so a reset would only cost logic.
   always_ff @(posedge clk_i) begin
      if (wr && !flush_i) begin
         mem[wp] <= in_data_i;
      end
   end

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Directed self-checking bench for pipe_stage_fifo at DEPTH=2, 3 and 1.
// The PIPE_FIFO_BYPASS_EN macro selects the matching expectations.
module tb_pipe_stage_fifo;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;

   // DEPTH=2 instance
   logic       f2 = 0, v2 = 0, or2 = 0;
   logic [7:0] d2 = '0;
   logic       r2, ov2;
   logic [7:0] od2;
   logic [1:0] c2;
   // DEPTH=3 instance
   logic       f3 = 0, v3 = 0, or3 = 0;
   logic [7:0] d3 = '0;
   logic       r3, ov3;
   logic [7:0] od3;
   logic [1:0] c3;
   // DEPTH=1 instance
   logic       f1 = 0, v1 = 0, or1 = 0;
   logic [7:0] d1 = '0;
   logic       r1, ov1;
   logic [7:0] od1;
   logic [0:0] c1;

   pipe_stage_fifo #(.WIDTH(8), .DEPTH(2)) u2 (
      .clk_i(clk), .rst_i(rst_n), .flush_i(f2), .in_valid_i(v2), .in_ready_o(r2),
      .in_data_i(d2), .out_valid_o(ov2), .out_ready_i(or2), .out_data_o(od2), .count_o(c2));
   pipe_stage_fifo #(.WIDTH(8), .DEPTH(3)) u3 (
      .clk_i(clk), .rst_i(rst_n), .flush_i(f3), .in_valid_i(v3), .in_ready_o(r3),
      .in_data_i(d3), .out_valid_o(ov3), .out_ready_i(or3), .out_data_o(od3), .count_o(c3));
   pipe_stage_fifo #(.WIDTH(8), .DEPTH(1)) u1 (
      .clk_i(clk), .rst_i(rst_n), .flush_i(f1), .in_valid_i(v1), .in_ready_o(r1),
      .in_data_i(d1), .out_valid_o(ov1), .out_ready_i(or1), .out_data_o(od1), .count_o(c1));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int sent, rcv, cyc, pops;
      logic psh, pp;

      // Reset held low for 3 cycles
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_valid", ov2, 0);
         check("rst_ready", r2, 1);
         check("rst_count", c2, 0);
      end
      check("rst_count3", c3, 0);
      check("rst_valid1", ov1, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // DEPTH=2: fill with A1, B2, then drain
      v2 = 1; d2 = 8'hA1; or2 = 0;
      @(negedge clk);
      d2 = 8'hB2; #1;
      check("fill_cnt1", c2, 1);
      check("fill_head1", od2, 8'hA1);
      @(negedge clk);
      v2 = 0; #1;
      check("full_cnt", c2, 2);
      check("full_ready", r2, 0);
      check("full_head", od2, 8'hA1);
      or2 = 1;
      @(negedge clk); #1;
      check("drain_cnt1", c2, 1);
      check("drain_head", od2, 8'hB2);
      @(negedge clk); #1;
      check("drain_cnt0", c2, 0);
      check("drain_valid", ov2, 0);
      or2 = 0;

      // DEPTH=3: push 0..9 with out_ready toggling, order must hold across wrap
      sent = 0; rcv = 0; cyc = 0;
      or3 = 1;
      while (rcv < 10 && cyc < 80) begin
         v3 = (sent < 10);
         d3 = 8'(sent);
         #1;
         psh = v3 & r3;
         pp  = ov3 & or3;
         if (pp) begin
            check("d3_order", od3, rcv);
            rcv++;
         end
         if (psh) sent++;
         @(negedge clk);
         or3 = ~or3;
         cyc++;
      end
      v3 = 0; or3 = 0; #1;
      check("d3_received", rcv, 10);
      check("d3_empty", c3, 0);

      // DEPTH=2: flush while full with a push offered
      @(negedge clk);
      v2 = 1; d2 = 8'h11;
      @(negedge clk);
      d2 = 8'h22;
      @(negedge clk);
      d2 = 8'h33; f2 = 1;
      @(negedge clk);
      f2 = 0; v2 = 0; #1;
      check("flush_cnt", c2, 0);
      check("flush_valid", ov2, 0);
      // Flush with one entry while a push is accepted: the push is discarded
      v2 = 1; d2 = 8'h44;
      @(negedge clk);
      d2 = 8'h55; f2 = 1;
      @(negedge clk);
      f2 = 0; d2 = 8'h66;
      @(negedge clk);
      v2 = 0; #1;
      check("post_flush_cnt", c2, 1);
      check("post_flush_head", od2, 8'h66);
      or2 = 1;
      @(negedge clk);
      or2 = 0; #1;
      check("post_flush_empty", c2, 0);

      // DEPTH=1: continuous valid/ready for 8 cycles
      sent = 0; pops = 0;
      v1 = 1; or1 = 1;
      for (int i = 0; i < 8; i++) begin
         d1 = 8'(sent);
         #1;
         psh = v1 & r1;
         pp  = ov1 & or1;
         if (pp) begin
            check("d1_order", od1, pops);
            pops++;
         end
         if (psh) sent++;
         @(negedge clk);
      end
      v1 = 0; or1 = 0;
`ifdef PIPE_FIFO_BYPASS_EN
      check("d1_rate", pops, 8);
`else
      check("d1_rate", pops, 4);
`endif

      // Empty DEPTH=2 with 0x5A offered and out_ready=1
      @(negedge clk);
      v2 = 1; d2 = 8'h5A; or2 = 1; #1;
`ifdef PIPE_FIFO_BYPASS_EN
      check("byp_valid", ov2, 1);
      check("byp_data", od2, 8'h5A);
      @(negedge clk);
      v2 = 0; or2 = 0; #1;
      check("byp_cnt", c2, 0);
      check("byp_after", ov2, 0);
`else
      check("nobyp_valid", ov2, 0);
      @(negedge clk);
      v2 = 0; #1;
      check("nobyp_cnt", c2, 1);
      check("nobyp_data", od2, 8'h5A);
      @(negedge clk);
      or2 = 0; #1;
      check("nobyp_drain", c2, 0);
`endif

      // Asynchronous reset mid-operation drops all entries
      v2 = 1; d2 = 8'h77;
      @(negedge clk);
      d2 = 8'h78;
      @(negedge clk);
      v2 = 0; #1;
      check("mid_cnt", c2, 2);
      #2 rst_n = 0;
      #1;
      check("mid_rst_cnt", c2, 0);
      check("mid_rst_valid", ov2, 0);
      check("mid_rst_ready", r2, 1);
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
